seg7_frame_decoder: RTL and testbench

//  Receiver for serialised seven-segment frames; the inverse of the hex-to-7seg encoder.

---
 rtl/seg7_frame_decoder_pkg.sv | 35 +++
 rtl/seg7_to_hex.sv | 35 +++
 rtl/seg7_frame_decoder.sv | 121 ++++++++++++
 tb/tb_seg7_frame_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_frame_decoder_pkg.sv
// Shared definitions for the serial seven-segment frame decoder:
// glyph patterns (active-low, Seg[6:0]), FSM states and the FIFO entry layout.
package seg7_frame_decoder_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    typedef struct packed {
        logic [SEG_W-1:0] raw;
        logic             invalid;
        logic [3:0]       value;
    } entry_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational lookup from an active-low segment pattern back to its hex digit.
// Patterns outside the 16-glyph set report invalid with a zero value.
module seg7_to_hex
    import seg7_frame_decoder_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic             invalid,
    output logic [3:0]       value
);

    always_comb begin
        invalid = 1'b0;
        value   = 4'h0;
        case (seg)
            SEG_0:   value = 4'h0;
            SEG_1:   value = 4'h1;
            SEG_2:   value = 4'h2;
            SEG_3:   value = 4'h3;
            SEG_4:   value = 4'h4;
            SEG_5:   value = 4'h5;
            SEG_6:   value = 4'h6;
            SEG_7:   value = 4'h7;
            SEG_8:   value = 4'h8;
            SEG_9:   value = 4'h9;
            SEG_A:   value = 4'hA;
            SEG_B:   value = 4'hB;
            SEG_C:   value = 4'hC;
            SEG_D:   value = 4'hD;
            SEG_E:   value = 4'hE;
            SEG_F:   value = 4'hF;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Serial seven-segment frame receiver: shifts in 7-bit frames, decodes them
// and queues {raw, invalid, value} entries in a small valid/ready FIFO.
module seg7_frame_decoder
    import seg7_frame_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             SerData,
    input  logic             SerStrobe,
    input  logic             FrameStart,
    input  logic             OutReady,
    output logic             OutValid,
    output logic [3:0]       OutValue,
    output logic             OutInvalid,
    output logic [SEG_W-1:0] OutRaw,
    output logic             Busy,
    output logic             FrameErr,
    output logic             Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [SEG_W-1:0] shreg, shreg_n;
    logic [2:0]       cnt, cnt_n;
    logic             err_n;
    logic             frame_done;
    logic [SEG_W-1:0] frame;
    logic             dec_inv;
    logic [3:0]       dec_val;

    logic [AW:0]      wr_ptr, rd_ptr;
    entry_t           mem [DEPTH];
    entry_t           head;
    logic             empty, full, push, pop;

    // Bit 6 arrives live on SerData so the frame is decoded and pushed on its own strobe.
    assign frame = {SerData, shreg[5:0]};

    seg7_to_hex u_dec (
        .seg     (frame),
        .invalid (dec_inv),
        .value   (dec_val)
    );

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        cnt_n      = cnt;
        err_n      = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (SerStrobe && FrameStart) begin
                    shreg_n[0] = SerData;
                    cnt_n      = 3'd1;
                    state_n    = RECV;
                end
            end
            RECV: begin
                if (SerStrobe && FrameStart) begin
                    err_n      = 1'b1;
                    shreg_n[0] = SerData;
                    cnt_n      = 3'd1;
                end else if (SerStrobe && cnt == 3'd6) begin
                    frame_done = 1'b1;
                    cnt_n      = 3'd0;
                    state_n    = IDLE;
                end else if (SerStrobe) begin
                    shreg_n[cnt] = SerData;
                    cnt_n        = cnt + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && OutReady;
    assign push  = frame_done && (!full || pop);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= 3'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            FrameErr <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            cnt      <= cnt_n;
            FrameErr <= err_n;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (frame_done && !push) Overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries.
    always_ff @(posedge Clock) begin
        if (Resetn && push) begin
            mem[wr_ptr[AW-1:0]] <= '{raw: frame, invalid: dec_inv, value: dec_val};
        end
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign OutValid   = !empty;
    assign OutValue   = empty ? 4'h0 : head.value;
    assign OutInvalid = empty ? 1'b0 : head.invalid;
    assign OutRaw     = empty ? '0 : head.raw;
    assign Busy       = (state == RECV);

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder: glyph table sweep plus
// hand-written sequences for frame abort, overflow and mid-frame reset.
module tb_seg7_frame_decoder;

    localparam int DEPTH = 4;

    logic       Clock;
    logic       Resetn;
    logic       SerData;
    logic       SerStrobe;
    logic       FrameStart;
    logic       OutReady;
    logic       OutValid;
    logic [3:0] OutValue;
    logic       OutInvalid;
    logic [6:0] OutRaw;
    logic       Busy;
    logic       FrameErr;
    logic       Overflow;

    seg7_frame_decoder #(.DEPTH(DEPTH)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .SerData    (SerData),
        .SerStrobe  (SerStrobe),
        .FrameStart (FrameStart),
        .OutReady   (OutReady),
        .OutValid   (OutValid),
        .OutValue   (OutValue),
        .OutInvalid (OutInvalid),
        .OutRaw     (OutRaw),
        .Busy       (Busy),
        .FrameErr   (FrameErr),
        .Overflow   (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [6:0] raw;
        logic       inv;
        logic [3:0] val;
    } vec_t;

    vec_t vecs [19];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_head(input string name, input logic [6:0] raw,
                              input logic inv, input logic [3:0] val);
        check({name, ".valid"}, {31'd0, OutValid}, 32'd1);
        check({name, ".raw"}, {25'd0, OutRaw}, {25'd0, raw});
        check({name, ".inv"}, {31'd0, OutInvalid}, {31'd0, inv});
        check({name, ".val"}, {28'd0, OutValue}, {28'd0, val});
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic strobe_bit(input logic d, input logic fs);
        SerData    = d;
        SerStrobe  = 1'b1;
        FrameStart = fs;
        @(negedge Clock);
        SerStrobe  = 1'b0;
        FrameStart = 1'b0;
        SerData    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic send_frame(input logic [6:0] seg, input int gap,
                              input logic rdy_last);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) idle(gap);
            if (k == 6 && rdy_last) OutReady = 1'b1;
            strobe_bit(seg[k], k == 0);
            if (k == 6 && rdy_last) OutReady = 1'b0;
        end
    endtask

    task automatic pop_one();
        OutReady = 1'b1;
        @(negedge Clock);
        OutReady = 1'b0;
    endtask

    task automatic do_reset();
        Resetn     = 1'b0;
        SerData    = 1'b0;
        SerStrobe  = 1'b0;
        FrameStart = 1'b0;
        OutReady   = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{7'h40, 1'b0, 4'h0};
        vecs[1]  = '{7'h79, 1'b0, 4'h1};
        vecs[2]  = '{7'h24, 1'b0, 4'h2};
        vecs[3]  = '{7'h30, 1'b0, 4'h3};
        vecs[4]  = '{7'h19, 1'b0, 4'h4};
        vecs[5]  = '{7'h12, 1'b0, 4'h5};
        vecs[6]  = '{7'h02, 1'b0, 4'h6};
        vecs[7]  = '{7'h78, 1'b0, 4'h7};
        vecs[8]  = '{7'h00, 1'b0, 4'h8};
        vecs[9]  = '{7'h10, 1'b0, 4'h9};
        vecs[10] = '{7'h08, 1'b0, 4'hA};
        vecs[11] = '{7'h03, 1'b0, 4'hB};
        vecs[12] = '{7'h46, 1'b0, 4'hC};
        vecs[13] = '{7'h21, 1'b0, 4'hD};
        vecs[14] = '{7'h06, 1'b0, 4'hE};
        vecs[15] = '{7'h0E, 1'b0, 4'hF};
        vecs[16] = '{7'h7F, 1'b1, 4'h0};
        vecs[17] = '{7'h7E, 1'b1, 4'h0};
        vecs[18] = '{7'h41, 1'b1, 4'h0};

        Resetn     = 1'b0;
        SerData    = 1'b0;
        SerStrobe  = 1'b0;
        FrameStart = 1'b0;
        OutReady   = 1'b0;
        idle(2);
        Resetn = 1'b1;

        check("rst.valid", {31'd0, OutValid}, 32'd0);
        check("rst.value", {28'd0, OutValue}, 32'd0);
        check("rst.inv", {31'd0, OutInvalid}, 32'd0);
        check("rst.raw", {25'd0, OutRaw}, 32'd0);
        check("rst.busy", {31'd0, Busy}, 32'd0);
        check("rst.ferr", {31'd0, FrameErr}, 32'd0);
        check("rst.ovf", {31'd0, Overflow}, 32'd0);

        // Single frame for digit 2, visible right after the bit-6 edge.
        send_frame(7'h24, 0, 1'b0);
        check_head("f24", 7'h24, 1'b0, 4'h2);
        check("f24.busy", {31'd0, Busy}, 32'd0);
        pop_one();
        check("f24.popped", {31'd0, OutValid}, 32'd0);
        check("f24.rawclr", {25'd0, OutRaw}, 32'd0);

        // Glyph sweep with a continuously ready consumer and varied gaps.
        OutReady = 1'b1;
        for (int i = 0; i < 19; i++) begin
            send_frame(vecs[i].raw, i % 4, 1'b0);
            check_head($sformatf("tbl%0d", i), vecs[i].raw, vecs[i].inv,
                       vecs[i].val);
        end
        idle(1);
        OutReady = 1'b0;
        check("tbl.drained", {31'd0, OutValid}, 32'd0);
        check("tbl.ovf", {31'd0, Overflow}, 32'd0);

        // Abort: FrameStart on bit 4 restarts reception with a 0x79 frame.
        strobe_bit(1'b0, 1'b1);
        strobe_bit(1'b0, 1'b0);
        strobe_bit(1'b0, 1'b0);
        strobe_bit(1'b0, 1'b0);
        check("abort.busy", {31'd0, Busy}, 32'd1);
        strobe_bit(1'b1, 1'b1);
        check("abort.ferr", {31'd0, FrameErr}, 32'd1);
        check("abort.busy2", {31'd0, Busy}, 32'd1);
        strobe_bit(1'b0, 1'b0);
        check("abort.ferr_low", {31'd0, FrameErr}, 32'd0);
        strobe_bit(1'b0, 1'b0);
        strobe_bit(1'b1, 1'b0);
        strobe_bit(1'b1, 1'b0);
        strobe_bit(1'b1, 1'b0);
        strobe_bit(1'b1, 1'b0);
        check_head("abort", 7'h79, 1'b0, 4'h1);
        pop_one();
        check("abort.single", {31'd0, OutValid}, 32'd0);

        // Overflow: DEPTH+1 frames with no consumer.
        for (int i = 0; i <= DEPTH; i++) send_frame(vecs[i].raw, 1, 1'b0);
        check("ovf.set", {31'd0, Overflow}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check_head($sformatf("ovf%0d", i), vecs[i].raw, 1'b0, vecs[i].val);
            pop_one();
        end
        check("ovf.empty", {31'd0, OutValid}, 32'd0);
        check("ovf.sticky", {31'd0, Overflow}, 32'd1);

        // Full FIFO with a pop on the same edge as the final push.
        do_reset();
        check("ovf2.rst", {31'd0, Overflow}, 32'd0);
        for (int i = 0; i < DEPTH; i++) send_frame(vecs[i].raw, 0, 1'b0);
        send_frame(vecs[DEPTH].raw, 0, 1'b1);
        check("ovf2.none", {31'd0, Overflow}, 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            check_head($sformatf("ovf2_%0d", i), vecs[i].raw, 1'b0, vecs[i].val);
            pop_one();
        end
        check("ovf2.empty", {31'd0, OutValid}, 32'd0);

        // Reset mid-frame with two entries queued.
        send_frame(7'h40, 0, 1'b0);
        send_frame(7'h79, 0, 1'b0);
        strobe_bit(1'b0, 1'b1);
        strobe_bit(1'b1, 1'b0);
        strobe_bit(1'b0, 1'b0);
        check("mid.busy_pre", {31'd0, Busy}, 32'd1);
        do_reset();
        check("mid.valid", {31'd0, OutValid}, 32'd0);
        check("mid.busy", {31'd0, Busy}, 32'd0);
        check("mid.ferr", {31'd0, FrameErr}, 32'd0);
        check("mid.value", {28'd0, OutValue}, 32'd0);
        send_frame(7'h12, 2, 1'b0);
        check_head("mid.next", 7'h12, 1'b0, 4'h5);
        check("mid.ferr2", {31'd0, FrameErr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
